// File: rtl/divu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divu_pkg
// Description : Shared types and sizing helpers for the divu_seq sequential
//               unsigned divider. The default operand width matches the
//               mult block so a divider can sit directly behind a product.
// Revision    : 1.0 - initial release
// ============================================================================
package divu_pkg;

    // Operand width shared with mult instantiations.
    localparam int c_divu_n_default = 9;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divu_state_e;

    // Width of the iteration counter that must reach 2N-1.
    function automatic int divu_cnt_w(input int n);
        return (2 * n > 1) ? $clog2(2 * n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divu_step.sv
`default_nettype none
// ============================================================================
// Module      : divu_step
// Description : One restoring-division iteration. Shifts the next dividend
//               bit into the partial remainder, then subtracts the divisor
//               when the shifted value is not smaller than it.
// Revision    : 1.0 - initial release
// Ports       : rem_i     - partial remainder entering this step (N bits)
//               divisor_i - divisor (N bits)
//               bit_i     - dividend bit shifted in this step
//               rem_o     - partial remainder after this step (N bits)
//               q_o       - quotient bit produced by this step
// ============================================================================
module divu_step #(
    parameter int N = 9
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] divisor_i,
    input  logic         bit_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    // The shifted value needs N+1 bits; after a subtract (or when no subtract
    // is needed) the result is below the divisor, so N bits hold it. With a
    // zero divisor the subtract is a no-op and the top bit simply falls off,
    // which leaves the low dividend bits as the final remainder.
    logic [N:0] w_shift;
    logic [N:0] w_dvs_ext;
    logic [N:0] w_diff;
    logic       w_ge;

    assign w_shift   = {rem_i, bit_i};
    assign w_dvs_ext = {1'b0, divisor_i};
    assign w_ge      = (w_shift >= w_dvs_ext);
    assign w_diff    = w_shift - w_dvs_ext;

    assign q_o   = w_ge;
    assign rem_o = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];

endmodule
`default_nettype wire

// File: rtl/divu_seq.sv
`default_nettype none
// ============================================================================
// Module      : divu_seq
// Description : Sequential unsigned restoring divider. Divides a 2N-bit
//               dividend by an N-bit divisor, one quotient bit per clock,
//               with valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_valid  - dividend/divisor valid
//               in_ready  - an operand pair can be accepted
//               dividend  - 2N-bit unsigned dividend
//               divisor   - N-bit unsigned divisor
//               out_valid - result valid, held until accepted
//               out_ready - downstream accepts the result
//               quotient  - 2N-bit unsigned quotient
//               remainder - N-bit unsigned remainder
//               div_zero  - result was produced with a zero divisor
// Options     : DIVU_ZERO_BYPASS_EN - a zero divisor skips the iterations and
//               presents the (identical) result one edge after acceptance.
// ============================================================================
module divu_seq
    import divu_pkg::*;
#(
    parameter int N = c_divu_n_default
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
);

    localparam int CNT_W = divu_cnt_w(N);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(2 * N - 1);

    divu_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*N-1:0]   dvd_q;     // dividend, consumed MSB first
    logic [N-1:0]     dvs_q;
    logic [N-1:0]     rem_q;
    logic [2*N-1:0]   quo_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             div_zero_q;

    logic [N-1:0]     w_rem_nxt;
    logic             w_qbit;

    divu_step #(
        .N (N)
    ) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .bit_i     (dvd_q[2*N-1]),
        .rem_o     (w_rem_nxt),
        .q_o       (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        div_zero_q <= 1'b0;
`ifdef DIVU_ZERO_BYPASS_EN
                        if (divisor == '0) begin
                            // Same values the full iteration would produce.
                            quo_q       <= '1;
                            rem_q       <= dividend[N-1:0];
                            div_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end

                RUN: begin
                    dvd_q <= {dvd_q[2*N-2:0], 1'b0};
                    rem_q <= w_rem_nxt;
                    quo_q <= {quo_q[2*N-2:0], w_qbit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == c_last) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        div_zero_q  <= (dvs_q == '0);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = div_zero_q;

endmodule
`default_nettype wire
